pc_redirect_ctrl: RTL and testbench

Sequences control-flow redirects from the execute stage into the fetch stage. It takes the 3-bit PC-select code produced by the branch logic and the candidate targets. It then:
- drives a valid/ready redirect to fetch,
- stalls EXE while a redirect is pending,
- squashes wrong-path instructions for a fixed window,
- runs a CSR handshake to save EPC and cause before vectoring on an exception.

It sits between the EXE-stage branch logic and the IF stage / CSR file.

---
 rtl/pc_redirect_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Redirect sequencer between EXE branch logic and fetch: valid/ready redirect, EXE stall,
// wrong-path squash window and an EPC/cause CSR handshake ahead of exception vectoring.
module pc_redirect_ctrl #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned KILL_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            io_exe_valid,
   input  logic [2:0]      io_pc_sel,
   input  logic [XLEN-1:0] io_exe_pc,
   input  logic [XLEN-1:0] io_br_target,
   input  logic [XLEN-1:0] io_jmp_target,
   input  logic [XLEN-1:0] io_jalr_target,
   input  logic [XLEN-1:0] io_evec,
   input  logic [3:0]      io_excp_cause,
   input  logic            io_fetch_ready,
   input  logic            io_csr_ack,
   output logic            io_redirect_valid,
   output logic [XLEN-1:0] io_redirect_pc,
   output logic            io_kill,
   output logic            io_stall_exe,
   output logic            io_csr_req,
   output logic [XLEN-1:0] io_csr_epc,
   output logic [3:0]      io_csr_cause,
   output logic [15:0]     io_redirect_count
);

   localparam logic [2:0] KillLoad = 3'(KILL_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StRedir, StTrapCsr, StTrapRedir} state_e;

   state_e          state_q, state_d;
   logic [2:0]      kill_cnt_q, kill_cnt_d;
   logic [XLEN-1:0] redir_pc_q, redir_pc_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] evec_q, evec_d;
   logic [3:0]      cause_q, cause_d;
   logic [15:0]     count_q, count_d;

   logic            ev, sel_redir, sel_excp, accept;
   logic [XLEN-1:0] sel_target;

   // Reset also gates ev so the combinational IDLE outputs stay quiet while reset is held.
   assign ev = io_exe_valid && reset && (state_q == StIdle) && (kill_cnt_q == 3'd0);

   always_comb begin
      sel_redir  = 1'b0;
      sel_excp   = 1'b0;
      sel_target = '0;
      unique case (io_pc_sel)
         3'd1: begin
            sel_redir  = 1'b1;
            sel_target = {io_jalr_target[XLEN-1:1], 1'b0};
         end
         3'd2: begin
            sel_redir  = 1'b1;
            sel_target = io_br_target;
         end
         3'd3: begin
            sel_redir  = 1'b1;
            sel_target = io_jmp_target;
         end
         3'd4:    sel_excp = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         kill_cnt_q <= 3'd0;
         redir_pc_q <= '0;
         epc_q      <= '0;
         evec_q     <= '0;
         cause_q    <= 4'd0;
         count_q    <= 16'd0;
      end else begin
         state_q    <= state_d;
         kill_cnt_q <= kill_cnt_d;
         redir_pc_q <= redir_pc_d;
         epc_q      <= epc_d;
         evec_q     <= evec_d;
         cause_q    <= cause_d;
         count_q    <= count_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      redir_pc_d = redir_pc_q;
      epc_d      = epc_q;
      evec_d     = evec_q;
      cause_d    = cause_q;
      unique case (state_q)
         StIdle: begin
            if (ev && sel_redir && !io_fetch_ready) begin
               state_d    = StRedir;
               redir_pc_d = sel_target;
            end else if (ev && sel_excp) begin
               state_d = StTrapCsr;
               epc_d   = io_exe_pc;
               cause_d = io_excp_cause;
               evec_d  = io_evec;
            end
         end
         StRedir:     if (io_fetch_ready) state_d = StIdle;
         StTrapCsr:   if (io_csr_ack) state_d = StTrapRedir;
         StTrapRedir: if (io_fetch_ready) state_d = StIdle;
         default:     state_d = StIdle;
      endcase
      // An accept as the counter expires reloads it, so io_kill never drops between windows.
      if (accept) begin
         kill_cnt_d = KillLoad;
      end else if (kill_cnt_q != 3'd0) begin
         kill_cnt_d = kill_cnt_q - 3'd1;
      end else begin
         kill_cnt_d = 3'd0;
      end
      count_d = accept ? count_q + 16'd1 : count_q;
   end

   always_comb begin
      io_redirect_valid = 1'b0;
      io_redirect_pc    = '0;
      io_stall_exe      = 1'b0;
      io_csr_req        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ev && sel_redir) begin
               io_redirect_valid = 1'b1;
               io_redirect_pc    = sel_target;
            end
            io_stall_exe = ev && ((sel_redir && !io_fetch_ready) || sel_excp);
         end
         StRedir: begin
            io_redirect_valid = 1'b1;
            io_redirect_pc    = redir_pc_q;
            io_stall_exe      = 1'b1;
         end
         StTrapCsr: begin
            io_csr_req   = 1'b1;
            io_stall_exe = 1'b1;
         end
         StTrapRedir: begin
            io_redirect_valid = 1'b1;
            io_redirect_pc    = evec_q;
            io_stall_exe      = 1'b1;
         end
         default: ;
      endcase
      accept  = io_redirect_valid && io_fetch_ready;
      io_kill = accept || (kill_cnt_q != 3'd0);
   end

   assign io_csr_epc        = epc_q;
   assign io_csr_cause      = cause_q;
   assign io_redirect_count = count_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboarded bench for pc_redirect_ctrl: directed redirect, trap, squash, reset and wrap cases.
module tb_pc_redirect_ctrl;

   localparam int unsigned K = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        exe_valid = 1'b0, w_exe_valid = 1'b0;
   logic [2:0]  pc_sel = 3'd0, w_pc_sel = 3'd0;
   logic [31:0] exe_pc = '0, br_target = '0, jmp_target = '0, jalr_target = '0, evec = '0;
   logic [3:0]  excp_cause = 4'd0;
   logic        fetch_ready = 1'b0, csr_ack = 1'b0;

   logic        rv, kill, stall, csr_req;
   logic [31:0] rpc, epc;
   logic [3:0]  cause;
   logic [15:0] count;
   logic        w_rv, w_kill, w_stall, w_csr_req;
   logic [31:0] w_rpc, w_epc;
   logic [3:0]  w_cause;
   logic [15:0] w_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [15:0] cnt;
   } redir_t;
   typedef struct {
      logic [31:0] epc;
      logic [3:0]  cause;
   } csr_t;
   redir_t rq[$];
   csr_t   cq[$];
   redir_t re;
   csr_t   ce;

   always #5 clk = ~clk;

   pc_redirect_ctrl #(.XLEN(32), .KILL_CYCLES(K)) dut (
      .clk(clk), .reset(reset), .io_exe_valid(exe_valid), .io_pc_sel(pc_sel),
      .io_exe_pc(exe_pc), .io_br_target(br_target), .io_jmp_target(jmp_target),
      .io_jalr_target(jalr_target), .io_evec(evec), .io_excp_cause(excp_cause),
      .io_fetch_ready(fetch_ready), .io_csr_ack(csr_ack), .io_redirect_valid(rv),
      .io_redirect_pc(rpc), .io_kill(kill), .io_stall_exe(stall), .io_csr_req(csr_req),
      .io_csr_epc(epc), .io_csr_cause(cause), .io_redirect_count(count)
   );

   // Single-cycle squash lets this instance accept a jump every cycle for the wrap test.
   pc_redirect_ctrl #(.XLEN(32), .KILL_CYCLES(1)) dut_w (
      .clk(clk), .reset(reset), .io_exe_valid(w_exe_valid), .io_pc_sel(w_pc_sel),
      .io_exe_pc(exe_pc), .io_br_target(br_target), .io_jmp_target(jmp_target),
      .io_jalr_target(jalr_target), .io_evec(evec), .io_excp_cause(excp_cause),
      .io_fetch_ready(fetch_ready), .io_csr_ack(csr_ack), .io_redirect_valid(w_rv),
      .io_redirect_pc(w_rpc), .io_kill(w_kill), .io_stall_exe(w_stall),
      .io_csr_req(w_csr_req), .io_csr_epc(w_epc), .io_csr_cause(w_cause),
      .io_redirect_count(w_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every accepted redirect and every CSR handshake.
   always @(negedge clk) begin
      if (reset) begin
         if (rv && fetch_ready) begin
            if (rq.size() == 0) begin
               chk("unexpected_redirect", 32'd1, 32'd0);
            end else begin
               re = rq.pop_front();
               chk("sb_redirect_pc", rpc, re.pc);
               chk("sb_count_before_accept", {16'd0, count}, {16'd0, re.cnt});
            end
         end
         if (csr_req && csr_ack) begin
            if (cq.size() == 0) begin
               chk("unexpected_csr", 32'd1, 32'd0);
            end else begin
               ce = cq.pop_front();
               chk("sb_csr_epc", epc, ce.epc);
               chk("sb_csr_cause", {28'd0, cause}, {28'd0, ce.cause});
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, rv}, 32'd0);
      chk("rst_pc", rpc, 32'd0);
      chk("rst_kill", {31'd0, kill}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_csr_req", {31'd0, csr_req}, 32'd0);
      chk("rst_epc", epc, 32'd0);
      chk("rst_cause", {28'd0, cause}, 32'd0);
      chk("rst_count", {16'd0, count}, 32'd0);
      reset = 1'b1;
      cyc();

      // Branch with fetch ready: zero-cycle redirect, then K cycles of kill.
      exe_valid = 1'b1; pc_sel = 3'd2; br_target = 32'h100; fetch_ready = 1'b1;
      rq.push_back('{pc: 32'h100, cnt: 16'd0});
      @(negedge clk);
      chk("br_valid", {31'd0, rv}, 32'd1);
      chk("br_pc", rpc, 32'h100);
      chk("br_kill", {31'd0, kill}, 32'd1);
      chk("br_stall", {31'd0, stall}, 32'd0);
      cyc();
      exe_valid = 1'b0; pc_sel = 3'd0; fetch_ready = 1'b0;
      for (int i = 1; i < int'(K); i++) begin
         @(negedge clk);
         chk("br_kill_window", {31'd0, kill}, 32'd1);
         cyc();
      end
      @(negedge clk);
      chk("br_kill_end", {31'd0, kill}, 32'd0);
      chk("br_count", {16'd0, count}, 32'd1);
      cyc();

      // JALR with fetch stalled three cycles; bit 0 cleared and target latched.
      exe_valid = 1'b1; pc_sel = 3'd1; jalr_target = 32'h203; fetch_ready = 1'b0;
      rq.push_back('{pc: 32'h202, cnt: 16'd1});
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            exe_valid = 1'b0; jalr_target = 32'h555;
         end
         if (i == 3) fetch_ready = 1'b1;
         @(negedge clk);
         chk("jalr_valid", {31'd0, rv}, 32'd1);
         chk("jalr_pc", rpc, 32'h202);
         chk("jalr_stall", {31'd0, stall}, 32'd1);
         chk("jalr_kill", {31'd0, kill}, (i == 3) ? 32'd1 : 32'd0);
         cyc();
      end
      fetch_ready = 1'b0; pc_sel = 3'd0;
      repeat (K - 1) cyc();
      @(negedge clk);
      chk("jalr_kill_end", {31'd0, kill}, 32'd0);
      chk("jalr_count", {16'd0, count}, 32'd2);
      cyc();

      // Exception: detect, two TRAP_CSR cycles (ack in the second), vector redirect.
      exe_valid = 1'b1; pc_sel = 3'd4; exe_pc = 32'h80; excp_cause = 4'd2; evec = 32'h1C0;
      fetch_ready = 1'b1;
      cq.push_back('{epc: 32'h80, cause: 4'd2});
      rq.push_back('{pc: 32'h1C0, cnt: 16'd2});
      @(negedge clk);
      chk("exc_detect_stall", {31'd0, stall}, 32'd1);
      chk("exc_detect_valid", {31'd0, rv}, 32'd0);
      chk("exc_detect_csr_req", {31'd0, csr_req}, 32'd0);
      cyc();
      exe_valid = 1'b0; pc_sel = 3'd0; exe_pc = 32'hDEAD; excp_cause = 4'd9;
      @(negedge clk);
      chk("exc_csr_req", {31'd0, csr_req}, 32'd1);
      chk("exc_csr_epc", epc, 32'h80);
      chk("exc_csr_cause", {28'd0, cause}, 32'd2);
      chk("exc_csr_stall", {31'd0, stall}, 32'd1);
      chk("exc_csr_valid", {31'd0, rv}, 32'd0);
      cyc();
      csr_ack = 1'b1;
      @(negedge clk);
      chk("exc_ack_csr_req", {31'd0, csr_req}, 32'd1);
      cyc();
      csr_ack = 1'b0;
      @(negedge clk);
      chk("exc_redir_valid", {31'd0, rv}, 32'd1);
      chk("exc_redir_pc", rpc, 32'h1C0);
      chk("exc_redir_stall", {31'd0, stall}, 32'd1);
      chk("exc_redir_kill", {31'd0, kill}, 32'd1);
      cyc();

      // Jumps held during the squash window are ignored; the cycle after it is taken.
      exe_valid = 1'b1; pc_sel = 3'd3; jmp_target = 32'h300; fetch_ready = 1'b1;
      for (int i = 0; i < int'(K) - 1; i++) begin
         @(negedge clk);
         chk("sq_valid", {31'd0, rv}, 32'd0);
         chk("sq_kill", {31'd0, kill}, 32'd1);
         chk("sq_stall", {31'd0, stall}, 32'd0);
         chk("sq_csr_epc_hold", epc, 32'h80);
         cyc();
      end
      rq.push_back('{pc: 32'h300, cnt: 16'd3});
      @(negedge clk);
      chk("sq_after_valid", {31'd0, rv}, 32'd1);
      chk("sq_after_kill", {31'd0, kill}, 32'd1);
      cyc();
      exe_valid = 1'b0; pc_sel = 3'd0; fetch_ready = 1'b0;
      repeat (K - 1) cyc();
      @(negedge clk);
      chk("sq_kill_end", {31'd0, kill}, 32'd0);
      chk("sq_count", {16'd0, count}, 32'd4);
      cyc();

      // Reset in TRAP_CSR drops the request immediately.
      exe_valid = 1'b1; pc_sel = 3'd4; exe_pc = 32'h44; excp_cause = 4'd5; evec = 32'h200;
      cyc();
      exe_valid = 1'b0; pc_sel = 3'd0;
      @(negedge clk);
      chk("rt_csr_req", {31'd0, csr_req}, 32'd1);
      chk("rt_epc", epc, 32'h44);
      #2 reset = 1'b0;
      #1;
      chk("rt_rst_csr_req", {31'd0, csr_req}, 32'd0);
      chk("rt_rst_stall", {31'd0, stall}, 32'd0);
      chk("rt_rst_count", {16'd0, count}, 32'd0);
      chk("rt_rst_epc", epc, 32'd0);
      chk("rt_rst_cause", {28'd0, cause}, 32'd0);
      chk("rt_rst_valid", {31'd0, rv}, 32'd0);
      chk("rt_rst_kill", {31'd0, kill}, 32'd0);
      cyc();
      reset = 1'b1;
      exe_valid = 1'b1; pc_sel = 3'd0; fetch_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rt_sel0_valid", {31'd0, rv}, 32'd0);
         chk("rt_sel0_stall", {31'd0, stall}, 32'd0);
         chk("rt_sel0_kill", {31'd0, kill}, 32'd0);
         chk("rt_sel0_csr_req", {31'd0, csr_req}, 32'd0);
         cyc();
      end
      exe_valid = 1'b0;

      // Counter wrap after 65536 back-to-back accepted jumps.
      w_exe_valid = 1'b1; w_pc_sel = 3'd3; jmp_target = 32'h400; fetch_ready = 1'b1;
      #1;
      chk("wrap_pc", w_rpc, 32'h400);
      chk("wrap_kill", {31'd0, w_kill}, 32'd1);
      repeat (65535) @(posedge clk);
      #1;
      chk("wrap_count_ffff", {16'd0, w_count}, 32'h0000FFFF);
      @(posedge clk);
      #1;
      w_exe_valid = 1'b0; w_pc_sel = 3'd0; fetch_ready = 1'b0;
      chk("wrap_count_zero", {16'd0, w_count}, 32'd0);
      cyc();

      chk("sb_redirect_drained", rq.size(), 32'd0);
      chk("sb_csr_drained", cq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
